bs_job_scheduler: RTL and testbench
===================================

# bs_job_scheduler

Shares one Black-Scholes pricing engine (d1/d2 → normal CDF → option price) between NREQ independent requesters. A round-robin arbiter grants one requester at a time. The scheduler then captures and holds that requester's operands, pulses the engine start, and counts the engine's fixed latency, because the engine exposes no completion signal. It returns the captured price tagged with the requester index, and rejects non-positive operands without occupying the engine.

## Interface
- WIDTH, 32, operand/price width, signed Q16.16
- NREQ, 4, number of requesters (2..16)
- ENG_LAT, 32, cycles from engine start pulse to a valid OptionPrice (≥2)
- IDW, $clog2(NREQ), requester-index width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- abort  in  1  synchronous; drops the current job
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_spot, req_strike, req_timetm, req_sigma, req_rate  in  NREQ*WIDTH  packed operands; slot i = bits [i*WIDTH +: WIDTH]
- req_otype  in  NREQ  0 call, 1 put
- eng_start  out  1  one-cycle start pulse to the engine
- eng_spot, eng_strike, eng_timetm, eng_sigma, eng_rate  out  WIDTH  held operands
- eng_otype  out  1  held option type
- eng_price  in  WIDTH  engine OptionPrice
- res_valid  out  1  result available
- res_ready  in  1  result consumer accept
- res_id  out  IDW  requester index of the result
- res_price  out  WIDTH  captured price; 0 on error
- res_err  out  1  operand rejected
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, LAUNCH, BUSY, RESULT.
- IDLE:
  - The arbiter picks the first requester with req_valid, searching from ptr upward with wrap. req_ready[grant]=1 only in IDLE.
  - On handshake, capture the operands, otype and id, then set ptr ← (grant+1) mod NREQ.
  - Validation: spot, strike, timetm and sigma must each be >0. rate may be ≤0.
  - Valid operands → LAUNCH.
  - Invalid operands → RESULT with res_err=1, res_price=0. The engine is not started.
- LAUNCH: eng_start=1 for exactly this cycle. Load the counter with ENG_LAT-1 → BUSY.
- BUSY: decrement each cycle. At counter==0, register res_price ← eng_price, res_err=0 → RESULT.
- RESULT: res_valid=1. Hold res_id, res_price and res_err stable until res_valid&&res_ready, then → IDLE.
- eng_* operand outputs change only on an IDLE handshake. They stay stable throughout LAUNCH, BUSY and RESULT.
- abort:
  - In LAUNCH or BUSY: → IDLE with no result. A pending eng_start in LAUNCH is suppressed.
  - In RESULT: drops the result.
  - In IDLE: no handshake that cycle.
  - ptr keeps its updated value.
- Arithmetic: validation is a signed compare against 0 (MSB==0 and value≠0). There is no other datapath arithmetic.

## Timing
- Reset values:
  - State IDLE, ptr 0, counter 0.
  - eng_start 0, res_valid 0, res_err 0, res_id 0, res_price 0.
  - All eng_* operands 0, req_ready 0.
  - busy 0.
- Handshake at cycle H (valid operands):
  - eng_start is high in cycle H+1.
  - eng_price is sampled at the end of cycle H+1+ENG_LAT.
  - res_valid rises in cycle H+2+ENG_LAT.
- Error path: res_valid rises in cycle H+1.
- Back-to-back throughput: one job per ENG_LAT+3 cycles when res_ready is held high (IDLE cycle, LAUNCH, ENG_LAT BUSY cycles, RESULT).
- While not in IDLE, all req_ready bits are 0. Requests stay pending, and requesters must hold their operands while valid.
- If abort and res_ready are both asserted in RESULT, abort wins. The state still goes → IDLE, but no transfer is counted.
- Reset asserted mid-job clears everything asynchronously. The engine sees eng_start=0 and must be reset alongside the scheduler.

## Structure
- Shared package bs_pkg holds:
  - the state enum;
  - the Q16.16 constants Q_ONE=32'h0001_0000 and Q_ZERO;
  - the default WIDTH.
- Sub-module rr_arbiter (NREQ, IDW):
  - inputs req, ptr;
  - outputs gnt_onehot, gnt_idx, any.
  - It is purely combinational. The pointer register lives in the scheduler.
- The top level instantiates bs_job_scheduler between the request sources and the existing pricing engine. The engine's start, operands and OptionPrice connect directly to the eng_* ports.

## Test plan
- Single job: requester 2, spot 100.0 (0x0064_0000), strike 100.0, timetm 1.0, sigma 0.2 (0x0000_3333), rate 0.05 (0x0000_0CCD), call, with a behavioural engine model.
  - eng_start is high exactly 1 cycle after the handshake.
  - res_valid comes ENG_LAT+1 cycles later, with res_id=2, res_err=0.
  - res_price equals the model's price at the sample cycle.
- Fairness: all 4 requesters hold req_valid continuously, with res_ready=1. Grant order is 0,1,2,3,0. Job spacing is ENG_LAT+3 cycles.
- Validation: sigma=0 on requester 1.
  - res_valid comes 1 cycle after the handshake, with res_err=1, res_price=0, res_id=1.
  - eng_start never pulses.
- Backpressure: res_ready held low for 50 cycles.
  - res_* stay stable and req_ready stays 0.
  - After res_ready is raised, the next queued request is accepted in the following IDLE cycle.
- Abort in BUSY (counter mid-way): no res_valid, return to IDLE next cycle, and the next requester in round-robin order is granted.
- Reset pulsed low during BUSY: all outputs return to their reset values immediately, without waiting for a clock edge, and ptr=0 after release.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared types and constants for the Black-Scholes job scheduler.
// Operands and prices are signed Q16.16.
package bs_pkg;

  localparam int          BS_WIDTH = 32;
  localparam logic [31:0] Q_ONE    = 32'h0001_0000;
  localparam logic [31:0] Q_ZERO   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_RESULT
  } bs_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted req at or above ptr, wrapping.
// No latency, no state; the owner keeps and advances ptr.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  logic [IDW-1:0] j;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    j          = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = IDW'((int'(ptr) + i) % NREQ);
      if (!any && req[j]) begin
        any           = 1'b1;
        gnt_idx       = j;
        gnt_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bs_job_scheduler.sv
// Time-shares one fixed-latency pricing engine among NREQ requesters; result ENG_LAT+2 cycles after accept.
// Requests stall (req_ready=0) whenever a job or an unconsumed result is outstanding.
module bs_job_scheduler
  import bs_pkg::*;
#(
  parameter int WIDTH   = BS_WIDTH,
  parameter int NREQ    = 4,
  parameter int ENG_LAT = 32,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  abort,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_spot,
  input  logic [NREQ*WIDTH-1:0] req_strike,
  input  logic [NREQ*WIDTH-1:0] req_timetm,
  input  logic [NREQ*WIDTH-1:0] req_sigma,
  input  logic [NREQ*WIDTH-1:0] req_rate,
  input  logic [NREQ-1:0]       req_otype,
  output logic                  eng_start,
  output logic [WIDTH-1:0]      eng_spot,
  output logic [WIDTH-1:0]      eng_strike,
  output logic [WIDTH-1:0]      eng_timetm,
  output logic [WIDTH-1:0]      eng_sigma,
  output logic [WIDTH-1:0]      eng_rate,
  output logic                  eng_otype,
  input  logic [WIDTH-1:0]      eng_price,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH-1:0]      res_price,
  output logic                  res_err,
  output logic                  busy
);

  localparam int CW = $clog2(ENG_LAT);

  bs_state_t       state;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   cnt;

  logic [NREQ-1:0] gnt_onehot;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic            take;

  logic [WIDTH-1:0] sel_spot, sel_strike, sel_timetm, sel_sigma, sel_rate;
  logic             sel_otype;
  logic             ops_ok;

  function automatic logic is_pos(input logic [WIDTH-1:0] v);
    return !v[WIDTH-1] && (v != '0);
  endfunction

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (req_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign sel_spot   = req_spot  [int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_strike = req_strike[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_timetm = req_timetm[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_sigma  = req_sigma [int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_rate   = req_rate  [int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_otype  = req_otype[gnt_idx];
  // rate is allowed to be zero or negative; only the other four must be positive
  assign ops_ok     = is_pos(sel_spot) && is_pos(sel_strike) && is_pos(sel_timetm) && is_pos(sel_sigma);

  assign take      = (state == ST_IDLE) && !abort && gnt_any;
  // Gating with reset keeps req_ready low while reset is held and requests are pending
  assign req_ready = (take && reset) ? gnt_onehot : '0;
  assign eng_start = (state == ST_LAUNCH) && !abort;
  assign res_valid = (state == ST_RESULT);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      eng_spot   <= '0;
      eng_strike <= '0;
      eng_timetm <= '0;
      eng_sigma  <= '0;
      eng_rate   <= '0;
      eng_otype  <= 1'b0;
      res_id     <= '0;
      res_price  <= '0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            eng_spot   <= sel_spot;
            eng_strike <= sel_strike;
            eng_timetm <= sel_timetm;
            eng_sigma  <= sel_sigma;
            eng_rate   <= sel_rate;
            eng_otype  <= sel_otype;
            res_id     <= gnt_idx;
            ptr        <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            if (ops_ok) begin
              res_err <= 1'b0;
              state   <= ST_LAUNCH;
            end else begin
              res_err   <= 1'b1;
              res_price <= '0;
              state     <= ST_RESULT;
            end
          end
        end
        ST_LAUNCH: begin
          if (abort) begin
            state <= ST_IDLE;
          end else begin
            cnt   <= CW'(ENG_LAT-1);
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The engine has no done flag; the price is valid exactly when the count expires
          if (abort) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            res_price <= eng_price;
            res_err   <= 1'b0;
            state     <= ST_RESULT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESULT: begin
          if (abort || res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bs_job_scheduler.sv
// Bench for bs_job_scheduler: operand-validation table, directed multi-cycle sequences,
// then randomized traffic against a job-level timing model with a stand-in engine.
module tb_bs_job_scheduler;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int L   = 32;
  localparam int IDW = 2;

  typedef struct {
    logic [W-1:0] spot, strike, timetm, sigma, rate;
    logic         otype;
  } op_t;

  typedef struct {
    int   idx;
    op_t  op;
    logic exp_err;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           abort;
  logic [N-1:0]   req_valid, req_ready, req_otype;
  logic [N*W-1:0] req_spot, req_strike, req_timetm, req_sigma, req_rate;
  logic           eng_start, eng_otype;
  logic [W-1:0]   eng_spot, eng_strike, eng_timetm, eng_sigma, eng_rate, eng_price;
  logic           res_valid, res_ready, res_err, busy;
  logic [IDW-1:0] res_id;
  logic [W-1:0]   res_price;

  bs_job_scheduler #(.WIDTH(W), .NREQ(N), .ENG_LAT(L), .IDW(IDW)) dut (
    .clk(clk), .reset(rst_n), .abort(abort),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_spot(req_spot), .req_strike(req_strike), .req_timetm(req_timetm),
    .req_sigma(req_sigma), .req_rate(req_rate), .req_otype(req_otype),
    .eng_start(eng_start), .eng_spot(eng_spot), .eng_strike(eng_strike),
    .eng_timetm(eng_timetm), .eng_sigma(eng_sigma), .eng_rate(eng_rate),
    .eng_otype(eng_otype), .eng_price(eng_price),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_price(res_price), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, n_start = 0, start_cyc = -1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (eng_start) begin
      n_start   <= n_start + 1;
      start_cyc <= cyc;
    end
  end

  function automatic logic [W-1:0] price_fn(input op_t o);
    return (o.spot ^ {o.strike[15:0], o.strike[31:16]}) + o.timetm + (o.sigma << 3)
           - o.rate + (o.otype ? 32'h0000_5555 : 32'h0);
  endfunction

  // Stand-in engine: real price only in the one cycle ENG_LAT after start, noise otherwise
  op_t e_op;
  int  e_cnt;
  bit  e_live;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_live <= 1'b0;
      e_cnt  <= 0;
    end else if (eng_start) begin
      e_live      <= 1'b1;
      e_cnt       <= L - 1;
      e_op.spot   <= eng_spot;
      e_op.strike <= eng_strike;
      e_op.timetm <= eng_timetm;
      e_op.sigma  <= eng_sigma;
      e_op.rate   <= eng_rate;
      e_op.otype  <= eng_otype;
    end else if (e_live && e_cnt > 0) begin
      e_cnt <= e_cnt - 1;
    end else begin
      e_live <= 1'b0;
    end
  end
  assign eng_price = (e_live && e_cnt == 0) ? price_fn(e_op) : (32'hA5A5_0000 ^ W'(cyc * 977));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_op(input int idx, input op_t o);
    req_spot  [idx*W +: W] = o.spot;
    req_strike[idx*W +: W] = o.strike;
    req_timetm[idx*W +: W] = o.timetm;
    req_sigma [idx*W +: W] = o.sigma;
    req_rate  [idx*W +: W] = o.rate;
    req_otype[idx]         = o.otype;
  endtask

  function automatic bit pos(input logic [W-1:0] v);
    return $signed(v) > 0;
  endfunction

  function automatic bit op_ok(input op_t o);
    return pos(o.spot) && pos(o.strike) && pos(o.timetm) && pos(o.sigma);
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.spot   = W'($urandom_range(1, 32'h00FF_FFFF));
    o.strike = W'($urandom_range(1, 32'h00FF_FFFF));
    o.timetm = W'($urandom_range(1, 32'h0004_0000));
    o.sigma  = W'($urandom_range(1, 32'h0001_0000));
    o.rate   = $urandom;
    o.otype  = 1'($urandom_range(1));
    case ($urandom_range(9))
      0: o.spot   = '0;
      1: o.strike = 32'h8000_0000 | $urandom;
      2: o.timetm = '0;
      3: o.sigma  = 32'h8000_0000 | $urandom;
      default: ;
    endcase
    return o;
  endfunction

  // All helpers enter and leave just after a rising edge, except where noted
  task automatic wait_hs(input int idx, output int h);
    h = -1;
    for (int k = 0; k < 200 && h < 0; k++) begin
      @(negedge clk);
      if (req_ready[idx]) h = cyc;
      else begin @(posedge clk); #1; end
    end
  endtask

  // Leaves at the falling edge of the first result cycle when successful
  task automatic wait_res(output int r);
    r = -1;
    for (int k = 0; k < L + 10 && r < 0; k++) begin
      @(negedge clk);
      if (res_valid) r = cyc;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic reset_pulse();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t     tbl[8];
  op_t      base, cur[N];
  int       h, r, s0, ng;
  int       g_idx[5], g_cyc[5];
  bit       flag, flag2;
  logic [W-1:0]   snap_price;
  logic [IDW-1:0] snap_id;
  logic           snap_err;

  // random-phase model: a job is "in flight" with a countdown until its result shows
  bit             m_act;
  int             m_left, m_ptr, acc, g;
  logic [IDW-1:0] m_id;
  logic           m_err;
  logic [W-1:0]   m_price;
  logic [63:0]    act_v, exp_v;

  initial begin
    rst_n = 1'b0; abort = 1'b0; res_ready = 1'b0;
    req_valid = '0; req_otype = '0;
    req_spot = '0; req_strike = '0; req_timetm = '0; req_sigma = '0; req_rate = '0;

    base = '{spot: 32'h0064_0000, strike: 32'h0064_0000, timetm: 32'h0001_0000,
             sigma: 32'h0000_3333, rate: 32'h0000_0CCD, otype: 1'b0};
    for (int i = 0; i < 8; i++) tbl[i] = '{idx: i % N, op: base, exp_err: 1'b0};
    tbl[0].idx = 2;
    tbl[1].idx = 1; tbl[1].op.sigma  = '0;            tbl[1].exp_err = 1'b1;
    tbl[2].idx = 0; tbl[2].op.spot   = '0;            tbl[2].exp_err = 1'b1;
    tbl[3].idx = 3; tbl[3].op.strike = 32'hFFFF_0000; tbl[3].exp_err = 1'b1;
    tbl[4].idx = 1; tbl[4].op.timetm = '0;            tbl[4].exp_err = 1'b1;
    tbl[5].idx = 2; tbl[5].op.rate   = 32'hFFFF_3333; tbl[5].op.otype = 1'b1;
    tbl[6].idx = 0; tbl[6].op.sigma  = 32'h8000_0000; tbl[6].exp_err = 1'b1;
    tbl[7].idx = 3; tbl[7].op.spot   = 32'h0000_0001; tbl[7].op.strike = 32'h7FFF_FFFF;

    #2;
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_err", res_err, 0);
    check("rst_res_id", res_id, 0);
    check("rst_res_price", res_price, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_eng_ops", {eng_spot | eng_strike | eng_timetm | eng_sigma | eng_rate, eng_otype}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // operand validation / single-job table
    for (int i = 0; i < 8; i++) begin
      s0 = n_start;
      set_op(tbl[i].idx, tbl[i].op);
      req_valid[tbl[i].idx] = 1'b1;
      wait_hs(tbl[i].idx, h);
      check($sformatf("tbl%0d_handshake", i), h >= 0, 1);
      @(posedge clk); #1;
      req_valid[tbl[i].idx] = 1'b0;
      wait_res(r);
      check($sformatf("tbl%0d_result_seen", i), r >= 0, 1);
      if (h >= 0 && r >= 0) begin
        check($sformatf("tbl%0d_latency", i), r - h, tbl[i].exp_err ? 1 : L + 2);
        check($sformatf("tbl%0d_res_id", i), res_id, tbl[i].idx);
        check($sformatf("tbl%0d_res_err", i), res_err, tbl[i].exp_err);
        check($sformatf("tbl%0d_res_price", i), res_price, tbl[i].exp_err ? '0 : price_fn(tbl[i].op));
        check($sformatf("tbl%0d_start_pulses", i), n_start - s0, tbl[i].exp_err ? 0 : 1);
        if (!tbl[i].exp_err) check($sformatf("tbl%0d_start_cycle", i), start_cyc - h, 1);
        ack();
      end
    end

    // fairness with all four requesters continuously valid
    reset_pulse();
    for (int i = 0; i < N; i++) begin
      cur[i] = base; cur[i].spot = W'((i + 1) << 16);
      set_op(i, cur[i]);
    end
    req_valid = '1; res_ready = 1'b1; ng = 0;
    for (int k = 0; k < 5 * (L + 3) + 20 && ng < 5; k++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        g_idx[ng] = -1;
        for (int b = N - 1; b >= 0; b--) if (req_ready[b]) g_idx[ng] = b;
        g_cyc[ng] = cyc; ng++;
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    check("fair_grant_count", ng, 5);
    for (int i = 0; i < ng; i++) begin
      check($sformatf("fair_order%0d", i), g_idx[i], i % N);
      if (i > 0) check($sformatf("fair_spacing%0d", i), g_cyc[i] - g_cyc[i-1], L + 3);
    end
    flag = 1'b0;
    for (int k = 0; k < L + 10 && !flag; k++) begin
      @(negedge clk); flag = !busy;
      @(posedge clk); #1;
    end
    check("fair_drain", flag, 1);
    res_ready = 1'b0;

    // result backpressure; ptr is 1 here
    set_op(0, base); req_valid[0] = 1'b1;
    wait_hs(0, h);
    check("bp_handshake", h >= 0, 1);
    @(posedge clk); #1; req_valid[0] = 1'b0;
    wait_res(r);
    check("bp_result_seen", r >= 0, 1);
    check("bp_res_id", res_id, 0);
    set_op(3, base); req_valid[3] = 1'b1;
    snap_id = res_id; snap_price = res_price; snap_err = res_err;
    flag = 1'b1; flag2 = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (!(res_valid && res_id == snap_id && res_price == snap_price && res_err == snap_err)) flag = 1'b0;
      if (req_ready != '0) flag2 = 1'b0;
    end
    check("bp_res_stable", flag, 1);
    check("bp_req_ready_low", flag2, 1);
    res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    @(negedge clk);
    check("bp_next_accept", req_ready, 4'b1000);
    @(posedge clk); #1; req_valid[3] = 1'b0;
    wait_res(r);
    check("bp_next_id", res_id, 3);
    if (r >= 0) ack();

    // abort in mid-BUSY; ptr is 0 here
    set_op(1, base); req_valid[1] = 1'b1;
    wait_hs(1, h);
    check("abort_handshake", h >= 0, 1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0; set_op(0, base); req_valid[0] = 1'b1; req_valid[3] = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); flag |= res_valid;
      @(posedge clk); #1;
    end
    abort = 1'b1;
    @(negedge clk);
    check("abort_in_busy", {busy, res_valid, eng_start}, 3'b100);
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    check("abort_no_result", flag | res_valid, 0);
    check("abort_idle", busy, 0);
    check("abort_next_rr", req_ready, 4'b1000);
    @(posedge clk); #1; req_valid[3] = 1'b0; req_valid[0] = 1'b0;
    wait_res(r);
    check("abort_next_id", res_id, 3);
    if (r >= 0) ack();

    // asynchronous reset mid-BUSY; ptr is 0 here, becomes 3 after this grant
    set_op(2, base); req_valid[2] = 1'b1;
    wait_hs(2, h);
    @(posedge clk); #1;
    req_valid[2] = 1'b0; set_op(1, base); req_valid[1] = 1'b1; req_valid[3] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("areset_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_busy", busy, 0);
    check("areset_res_valid", res_valid, 0);
    check("areset_eng_start", eng_start, 0);
    check("areset_req_ready", req_ready, 0);
    check("areset_res", {res_id, res_err, res_price}, 0);
    check("areset_eng_ops", {eng_spot | eng_strike | eng_timetm | eng_sigma | eng_rate, eng_otype}, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("areset_ptr_zero", req_ready, 4'b0010);
    req_valid = '0;
    @(posedge clk); #1;

    // randomized traffic against the job-level model
    reset_pulse();
    m_act = 1'b0; m_left = 0; m_ptr = 0; acc = -1;
    m_id = '0; m_err = 1'b0; m_price = '0;
    for (int c = 0; c < 3000; c++) begin
      if (acc >= 0) begin req_valid[acc] = 1'b0; acc = -1; end
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(3) == 0) begin
          cur[i] = rand_op(); set_op(i, cur[i]); req_valid[i] = 1'b1;
        end
      res_ready = 1'($urandom_range(1));
      abort     = ($urandom_range(39) == 0);
      @(negedge clk);
      g = -1;
      if (!m_act && !abort)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_v = {22'd0, (g >= 0) ? 4'(1 << g) : 4'd0, m_act && m_left == L + 1 && !abort,
               m_act, m_act && m_left == 0,
               (m_act && m_left == 0) ? {m_id, m_err, m_price} : 35'd0};
      act_v = {22'd0, req_ready, eng_start, busy, res_valid,
               (m_act && m_left == 0) ? {res_id, res_err, res_price} : 35'd0};
      check("rand_cycle", act_v, exp_v);
      if (m_act) begin
        if (abort) m_act = 1'b0;
        else if (m_left > 0) m_left--;
        else if (res_ready) m_act = 1'b0;
      end else if (g >= 0) begin
        m_act = 1'b1; acc = g; m_ptr = (g + 1) % N; m_id = IDW'(g);
        m_err   = !op_ok(cur[g]);
        m_price = m_err ? '0 : price_fn(cur[g]);
        m_left  = m_err ? 0 : L + 1;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0; res_ready = 1'b0; req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
